// File: rtl/acc_seq_ctrl_if.sv
// rtl/acc_seq_ctrl_if.sv - sequencer <-> ROM/ALU/regfile/dmem signal bundle
// Purpose: groups every non-clock/reset signal of acc_seq_ctrl.
// master: the sequencer (drives fetch, ALU control, strobes, status).
// slave : the surrounding CPU (drives start, ROM data, ALU results).
interface acc_seq_ctrl_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             inst_req;
    logic [PC_W-1:0]  inst_addr;
    logic             inst_valid;
    logic [8:0]       inst_in;
    logic [3:0]       alu_op;
    logic             reg_exe;
    logic             imm_exe;
    logic             reg_to_acc;
    logic             acc_to_reg;
    logic [7:0]       imm_out;
    logic [3:0]       rf_addr;
    logic             sc_in;
    logic             alu_sc_out;
    logic             alu_branch;
    logic             acc_we;
    logic             rf_we;
    logic             dmem_re;
    logic             dmem_we;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        input  start, inst_valid, inst_in, alu_sc_out, alu_branch,
        output inst_req, inst_addr, alu_op, reg_exe, imm_exe, reg_to_acc, acc_to_reg,
               imm_out, rf_addr, sc_in, acc_we, rf_we, dmem_re, dmem_we, busy, done,
               cycle_cnt
    );

    modport slave (
        output start, inst_valid, inst_in, alu_sc_out, alu_branch,
        input  inst_req, inst_addr, alu_op, reg_exe, imm_exe, reg_to_acc, acc_to_reg,
               imm_out, rf_addr, sc_in, acc_we, rf_we, dmem_re, dmem_we, busy, done,
               cycle_cnt
    );
endinterface

// File: rtl/acc_seq_ctrl.sv
// rtl/acc_seq_ctrl.sv - multi-cycle fetch/decode sequencer for the accumulator datapath
// Purpose: fetches 9-bit instructions ({op[3:0], mode, reg/imm[3:0]}), drives the ALU
// opcode and mode flags, owns PC, carry flag and the acc/regfile/dmem write strobes.
// Ports: i_clk  - clock, all state changes on posedge
//        i_rst  - synchronous active-high reset
//        bus    - acc_seq_ctrl_if.master (start, fetch handshake, ALU control, strobes,
//                 busy/done status, saturating busy-cycle counter)
module acc_seq_ctrl #(
    parameter int PC_W     = 8,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    acc_seq_ctrl_if.master bus
);
    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_SL     = 4'h2;
    localparam logic [3:0] OP_SR     = 4'h3;
    localparam logic [3:0] OP_INVERT = 4'h4;
    localparam logic [3:0] OP_ASSIGN = 4'h5;
    localparam logic [3:0] OP_MOV    = 4'h6;
    localparam logic [3:0] OP_SW     = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_BEQ    = 4'h9;
    localparam logic [3:0] OP_BGE    = 4'hA;
    localparam logic [3:0] OP_BNE    = 4'hB;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam logic [PC_W-1:0] L_START = PC_W'(START_PC);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [8:0]       r_inst;
    logic             r_sc;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_next;
    logic [PC_W-1:0]  w_pc_next;
    logic             w_sc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_latch;
    logic             w_req;
    logic             w_acc_we;
    logic             w_rf_we;
    logic             w_dre;
    logic             w_dwe;
    logic [3:0]       w_alu_op;
    logic             w_exec;
    logic             w_busy;
    logic [3:0]       w_op;
    logic             w_mode;

    assign w_op   = r_inst[8:5];
    assign w_mode = r_inst[4];
    assign w_exec = (r_state == S_EXEC);
    assign w_busy = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_MEM);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_pc    <= L_START;
            r_inst  <= '0;
            r_sc    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            r_sc    <= w_sc_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_inst <= bus.inst_in;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_sc_next  = r_sc;
        w_cnt_next = r_cnt;
        w_latch    = 1'b0;
        w_req      = 1'b0;
        w_acc_we   = 1'b0;
        w_rf_we    = 1'b0;
        w_dre      = 1'b0;
        w_dwe      = 1'b0;
        w_alu_op   = 4'h0;

        if (w_busy && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end

        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    w_next     = S_FETCH;
                    w_pc_next  = L_START;
                    w_sc_next  = 1'b0;
                    w_cnt_next = '0;
                end
            end
            S_FETCH: begin
                w_req = 1'b1;
                if (bus.inst_valid) begin
                    w_latch = 1'b1;
                    w_next  = S_EXEC;
                end
            end
            S_EXEC: begin
                // Default exit: fall through to the next instruction.
                w_next    = S_FETCH;
                w_pc_next = r_pc + PC_W'(1);
                w_alu_op  = w_op;
                case (w_op)
                    OP_ADD, OP_SUB, OP_SL, OP_SR: begin
                        w_acc_we  = 1'b1;
                        w_sc_next = bus.alu_sc_out;
                    end
                    OP_ASSIGN: w_acc_we = 1'b1;
                    OP_MOV: begin
                        w_acc_we = w_mode;
                        w_rf_we  = ~w_mode;
                    end
                    OP_SW: w_dwe = 1'b1;
                    OP_LW: begin
                        // PC advances when MEM completes, not here.
                        w_dre     = 1'b1;
                        w_next    = S_MEM;
                        w_pc_next = r_pc;
                    end
                    OP_BEQ, OP_BGE, OP_BNE: begin
                        w_pc_next = r_pc + (bus.alu_branch ? PC_W'(2) : PC_W'(1));
                    end
                    OP_HALT: begin
                        w_alu_op  = 4'h0;
                        w_next    = S_HALT;
                        w_pc_next = r_pc;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                w_dre     = 1'b1;
                w_acc_we  = 1'b1;
                w_pc_next = r_pc + PC_W'(1);
                w_next    = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes are masked by reset so an abort never leaves a write behind in that cycle.
    assign bus.inst_req   = w_req & ~i_rst;
    assign bus.acc_we     = w_acc_we & ~i_rst;
    assign bus.rf_we      = w_rf_we & ~i_rst;
    assign bus.dmem_re    = w_dre & ~i_rst;
    assign bus.dmem_we    = w_dwe & ~i_rst;
    assign bus.inst_addr  = r_pc;
    assign bus.alu_op     = w_alu_op;
    assign bus.reg_exe    = w_exec & w_mode;
    assign bus.imm_exe    = w_exec & ~w_mode;
    assign bus.reg_to_acc = w_exec & (w_op == OP_MOV) & w_mode;
    assign bus.acc_to_reg = w_exec & (w_op == OP_MOV) & ~w_mode;
    assign bus.imm_out    = {4'b0000, r_inst[3:0]};
    assign bus.rf_addr    = r_inst[3:0];
    assign bus.sc_in      = r_sc;
    assign bus.busy       = w_busy;
    assign bus.done       = (r_state == S_HALT);
    assign bus.cycle_cnt  = r_cnt;
endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb/tb_acc_seq_ctrl.sv - directed self-checking bench for acc_seq_ctrl
module tb_acc_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    acc_seq_ctrl_if #(.PC_W(8), .CNT_W(16)) bus_a ();
    acc_seq_ctrl_if #(.PC_W(4), .CNT_W(3))  bus_b ();

    acc_seq_ctrl #(.PC_W(8), .START_PC(0), .CNT_W(16)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    acc_seq_ctrl #(.PC_W(4), .START_PC(14), .CNT_W(3)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    // Instruction ROMs with programmable fetch length (cycles inst_req is high).
    logic [8:0] rom_a [256];
    logic [8:0] rom_b [16];
    logic [7:0] fetch_cycles = 8'd1;
    logic [7:0] wcnt_a = 8'd0;

    always @(posedge clk)
        wcnt_a <= (bus_a.inst_req && !bus_a.inst_valid) ? wcnt_a + 8'd1 : 8'd0;

    assign bus_a.inst_valid = bus_a.inst_req && (wcnt_a >= fetch_cycles - 8'd1);
    assign bus_a.inst_in    = rom_a[bus_a.inst_addr];
    assign bus_b.inst_valid = bus_b.inst_req;
    assign bus_b.inst_in    = rom_b[bus_b.inst_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       start, sc, br;
        logic       req;
        int         addr;
        logic       busy, done;
        int         op;
        logic       acc, rf, dre, dwe, scq;
        int         cnt;
        logic [3:0] flags;  // {reg_exe, imm_exe, reg_to_acc, acc_to_reg}
    } vec_t;

    vec_t vt [12];

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        bus_a.start = 0; bus_a.alu_sc_out = 0; bus_a.alu_branch = 0;
        bus_b.start = 0; bus_b.alu_sc_out = 0; bus_b.alu_branch = 0;
        for (int i = 0; i < 256; i++) rom_a[i] = 9'h1E0;
        for (int i = 0; i < 16; i++)  rom_b[i] = 9'h1E0;

        // ADD imm 5; SUB reg r2; HALT, zero-latency ROM, then restart from HALT.
        rom_a[0] = 9'h005; rom_a[1] = 9'h032; rom_a[2] = 9'h1E0;
        //         st sc br  req addr busy done op acc rf dre dwe scq cnt flags
        vt[0]  = '{1, 0, 0,  0,  0,   0,   0,   0, 0,  0, 0,  0,  0,  0,  4'b0000};
        vt[1]  = '{0, 0, 0,  1,  0,   1,   0,   0, 0,  0, 0,  0,  0,  0,  4'b0000};
        vt[2]  = '{0, 1, 0,  0,  0,   1,   0,   0, 1,  0, 0,  0,  0,  1,  4'b0100};
        vt[3]  = '{0, 0, 0,  1,  1,   1,   0,   0, 0,  0, 0,  0,  1,  2,  4'b0000};
        vt[4]  = '{0, 1, 0,  0,  1,   1,   0,   1, 1,  0, 0,  0,  1,  3,  4'b1000};
        vt[5]  = '{0, 0, 0,  1,  2,   1,   0,   0, 0,  0, 0,  0,  1,  4,  4'b0000};
        vt[6]  = '{0, 0, 0,  0,  2,   1,   0,   0, 0,  0, 0,  0,  1,  5,  4'b0100};
        vt[7]  = '{1, 0, 0,  0,  2,   0,   1,   0, 0,  0, 0,  0,  1,  6,  4'b0000};
        vt[8]  = '{0, 0, 0,  1,  0,   1,   0,   0, 0,  0, 0,  0,  0,  0,  4'b0000};
        vt[9]  = '{1, 0, 0,  0,  0,   1,   0,   0, 1,  0, 0,  0,  0,  1,  4'b0100};
        vt[10] = '{1, 0, 0,  1,  1,   1,   0,   0, 0,  0, 0,  0,  0,  2,  4'b0000};
        vt[11] = '{0, 0, 0,  0,  1,   1,   0,   1, 1,  0, 0,  0,  0,  3,  4'b1000};

        do_reset();
        check("reset b addr", bus_b.inst_addr, 14);
        check("reset b busy", bus_b.busy, 0);

        for (int i = 0; i < 12; i++) begin
            bus_a.start      = vt[i].start;
            bus_a.alu_sc_out = vt[i].sc;
            bus_a.alu_branch = vt[i].br;
            #1;
            check($sformatf("row%0d req", i),   bus_a.inst_req, vt[i].req);
            check($sformatf("row%0d addr", i),  bus_a.inst_addr, vt[i].addr);
            check($sformatf("row%0d busy", i),  bus_a.busy, vt[i].busy);
            check($sformatf("row%0d done", i),  bus_a.done, vt[i].done);
            check($sformatf("row%0d op", i),    bus_a.alu_op, vt[i].op);
            check($sformatf("row%0d acc", i),   bus_a.acc_we, vt[i].acc);
            check($sformatf("row%0d rf", i),    bus_a.rf_we, vt[i].rf);
            check($sformatf("row%0d dre", i),   bus_a.dmem_re, vt[i].dre);
            check($sformatf("row%0d dwe", i),   bus_a.dmem_we, vt[i].dwe);
            check($sformatf("row%0d sc", i),    bus_a.sc_in, vt[i].scq);
            check($sformatf("row%0d cnt", i),   bus_a.cycle_cnt, vt[i].cnt);
            check($sformatf("row%0d flags", i),
                  {bus_a.reg_exe, bus_a.imm_exe, bus_a.reg_to_acc, bus_a.acc_to_reg},
                  vt[i].flags);
            step();
        end
        bus_a.start = 0; bus_a.alu_sc_out = 0; bus_a.alu_branch = 0;

        // Reset in the EXEC cycle of an ADD: strobe suppressed, state cleared.
        rom_a[0] = 9'h001; rom_a[1] = 9'h002; rom_a[2] = 9'h1E0;
        do_reset();
        bus_a.start = 1; step(); bus_a.start = 0;   // FETCH 0
        step();                                     // EXEC ADD 0
        bus_a.alu_sc_out = 1; step(); bus_a.alu_sc_out = 0;  // FETCH 1
        check("t1 sc before", bus_a.sc_in, 1);
        step();                                     // EXEC ADD 1
        check("t1 acc_we pre", bus_a.acc_we, 1);
        check("t1 imm_out", bus_a.imm_out, 2);
        rst = 1; #1;
        check("t1 acc_we in reset", bus_a.acc_we, 0);
        step(); rst = 0; #1;
        check("t1 busy", bus_a.busy, 0);
        check("t1 done", bus_a.done, 0);
        check("t1 pc", bus_a.inst_addr, 0);
        check("t1 sc", bus_a.sc_in, 0);
        check("t1 cnt", bus_a.cycle_cnt, 0);

        // Branch skip/fall-through, SL carry, MOV/SW strobes, restart from HALT.
        rom_a[0] = 9'h001; rom_a[1] = 9'h041; rom_a[2] = 9'h080; rom_a[3] = 9'h160;
        rom_a[4] = 9'h0D3; rom_a[5] = 9'h0C4; rom_a[6] = 9'h0E5; rom_a[7] = 9'h1E0;
        bus_a.start = 1; step(); bus_a.start = 0;   // F0
        step(); step(); step();                     // E0 F1 E1
        check("t6 sl op", bus_a.alu_op, 2);
        bus_a.alu_sc_out = 1; step(); bus_a.alu_sc_out = 0;  // F2
        check("t6 sc after sl", bus_a.sc_in, 1);
        step();                                     // E2 INVERT
        check("invert op", bus_a.alu_op, 4);
        check("invert no acc_we", bus_a.acc_we, 0);
        step(); step();                             // F3 E3
        check("bne op", bus_a.alu_op, 11);
        bus_a.alu_branch = 1; step(); bus_a.alu_branch = 0;  // F5
        check("t3 bne taken pc", bus_a.inst_addr, 5);
        step();                                     // E5 MOV imm
        check("mov imm rf_we", bus_a.rf_we, 1);
        check("mov imm acc_to_reg", bus_a.acc_to_reg, 1);
        check("mov imm acc_we", bus_a.acc_we, 0);
        step(); step();                             // F6 E6
        check("sw dmem_we", bus_a.dmem_we, 1);
        step(); step(); step();                     // F7 E7 HALT
        check("halt done", bus_a.done, 1);
        check("halt sc kept", bus_a.sc_in, 1);
        bus_a.start = 1; step(); bus_a.start = 0;   // F0
        check("t6 restart sc", bus_a.sc_in, 0);
        check("t6 restart pc", bus_a.inst_addr, 0);
        for (int i = 0; i < 7; i++) step();         // up to E3
        bus_a.alu_branch = 0; step();               // F4
        check("t3 bne not taken pc", bus_a.inst_addr, 4);
        step();                                     // E4 MOV reg
        check("mov reg acc_we", bus_a.acc_we, 1);
        check("mov reg reg_to_acc", bus_a.reg_to_acc, 1);
        check("mov reg rf_addr", bus_a.rf_addr, 3);

        // LW with a 3-cycle fetch.
        rom_a[0] = 9'h103; rom_a[1] = 9'h1E0;
        fetch_cycles = 8'd3;
        do_reset();
        bus_a.start = 1; step(); bus_a.start = 0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t5 req f%0d", i), bus_a.inst_req, 1);
            check($sformatf("t5 dre f%0d", i), bus_a.dmem_re, 0);
            step();
        end
        check("t5 exec req", bus_a.inst_req, 0);
        check("t5 exec dre", bus_a.dmem_re, 1);
        check("t5 exec acc_we", bus_a.acc_we, 0);
        check("t5 exec op", bus_a.alu_op, 8);
        step();
        check("t5 mem dre", bus_a.dmem_re, 1);
        check("t5 mem acc_we", bus_a.acc_we, 1);
        check("t5 mem busy", bus_a.busy, 1);
        check("t5 mem pc", bus_a.inst_addr, 0);
        step();
        check("t5 next pc", bus_a.inst_addr, 1);
        check("t5 next dre", bus_a.dmem_re, 0);
        check("t5 next acc_we", bus_a.acc_we, 0);
        for (int i = 0; i < 4; i++) step();
        check("t5 done", bus_a.done, 1);
        check("t5 cnt", bus_a.cycle_cnt, 9);
        fetch_cycles = 8'd1;

        // PC_W=4 wrap on a taken skip, and CNT_W=3 saturation.
        rom_b[14] = 9'h001; rom_b[15] = 9'h120;
        rom_b[1] = 9'h001; rom_b[2] = 9'h001; rom_b[3] = 9'h1E0;
        bus_b.start = 1; step(); bus_b.start = 0;   // F14
        check("t4 start pc", bus_b.inst_addr, 14);
        step(); step(); step();                     // E14 F15 E15
        bus_b.alu_branch = 1; step(); bus_b.alu_branch = 0;  // F1
        check("t4 wrap pc", bus_b.inst_addr, 1);
        check("t4 cnt mid", bus_b.cycle_cnt, 4);
        for (int i = 0; i < 6; i++) step();
        check("t4 done", bus_b.done, 1);
        check("t4 cnt saturated", bus_b.cycle_cnt, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
